// File: rtl/decoded_event_arbiter.sv
// Captures decoded one-hot events into pending flags and offers them downstream
// one at a time as binary indices, chosen round-robin, over a valid/ready handshake.
module decoded_event_arbiter #(
  parameter int unsigned N_LINES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] dec_in,
  input  logic               dec_valid,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [3:0]         evt_idx,
  output logic [N_LINES-1:0] pending,
  output logic               onehot_err,
  output logic [7:0]         drop_cnt
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state, state_nx;
  logic [3:0]         last_grant;
  logic [3:0]         sel_idx;
  logic [3:0]         cand;
  logic               sel_found;
  logic               load;
  logic [N_LINES-1:0] clr_mask;
  logic [N_LINES-1:0] cap_mask;
  logic [N_LINES-1:0] pending_nx;
  logic               drop;
  logic               multi_hot;
  logic               bad_vec;

  // Round-robin search over registered pending, starting just after last_grant.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_LINES; i++) begin
      cand = 4'((32'(last_grant) + i) % N_LINES);
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          load     = 1'b1;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          if (sel_found) load = 1'b1;
          else           state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    evt_valid = (state == OFFER);
  end

  // A line cleared by this cycle's load and recaptured in the same cycle stays set
  // and is not a collision, so the clear mask is applied before the drop test.
  always_comb begin
    clr_mask = '0;
    if (load) clr_mask[sel_idx] = 1'b1;
    cap_mask   = dec_valid ? dec_in : '0;
    pending_nx = (pending & ~clr_mask) | cap_mask;
    drop       = |(cap_mask & pending & ~clr_mask);
    multi_hot  = |(dec_in & (dec_in - {{(N_LINES-1){1'b0}}, 1'b1}));
    bad_vec    = dec_valid && ((dec_in == '0) || multi_hot);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      evt_idx    <= '0;
      last_grant <= 4'(N_LINES - 1);
      onehot_err <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      pending <= pending_nx;
      if (load) begin
        evt_idx    <= sel_idx;
        last_grant <= sel_idx;
      end
      if (bad_vec) onehot_err <= 1'b1;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: doc/decoded_event_arbiter.md
DECODED_EVENT_ARBITER -- requirements
Module: decoded_event_arbiter

Interface
REQ-001 Parameter: N_LINES, default 16, number of decoded event lines; index width IDX_W = 4 is fixed and N_LINES SHALL NOT exceed 16.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 dec_in  input  N_LINES  decoded event vector from the upstream 4-to-16 decoder; one-hot expected.
REQ-005 dec_valid  input  1  qualifies dec_in for one cycle.
REQ-006 evt_valid  output  1  an event index is offered downstream.
REQ-007 evt_ready  input  1  downstream accepts the offered index.
REQ-008 evt_idx  output  4  binary index of the offered event line.
REQ-009 pending  output  N_LINES  registered flags for captured events not yet offered.
REQ-010 onehot_err  output  1  sticky flag: a non-one-hot dec_in was received.
REQ-011 drop_cnt  output  8  saturating count of events lost because that line was already pending.

Function
REQ-012 Capture: when dec_valid=1, every set bit of dec_in SHALL be ORed into pending on the next rising edge.
REQ-013 Capture with dec_valid=1 and dec_in=0 SHALL change no pending flag and SHALL set onehot_err.
REQ-014 dec_valid=1 with more than one bit set in dec_in SHALL set onehot_err, and all set bits SHALL still be captured.
REQ-015 onehot_err SHALL stay set until rst.
REQ-016 Drop: drop_cnt SHALL increment by 1 per cycle when any dec_in bit, with dec_valid=1, hits a pending flag that is not cleared in that same cycle.
REQ-017 drop_cnt SHALL increment by at most 1 per cycle, regardless of how many lines collide.
REQ-018 drop_cnt SHALL saturate at 255.
REQ-019 Same-cycle set and clear of one line (load and capture coincide) SHALL leave the flag set and SHALL NOT count as a drop.
REQ-020 FSM states: IDLE and OFFER.
REQ-021 IDLE: evt_valid=0.
REQ-022 IDLE -> OFFER: when pending is non-zero, the FSM SHALL perform a load and move to OFFER.
REQ-023 Load: select a line round-robin, register its index into evt_idx, clear that pending flag, and set evt_valid=1 on the next edge.
REQ-024 OFFER: evt_valid=1, and evt_idx SHALL stay stable until a cycle with evt_ready=1.
REQ-025 OFFER handshake: evt_valid=1 and evt_ready=1 completes the transfer.
REQ-026 After a transfer, if pending is non-zero, the FSM SHALL load the next line in the same cycle and stay in OFFER, giving back-to-back transfers with no bubble.
REQ-027 After a transfer, if pending is zero, the FSM SHALL go to IDLE.
REQ-028 Round-robin: the search SHALL start at (last_grant+1) mod N_LINES, ascending with wrap-around.
REQ-029 last_grant SHALL update on every load.
REQ-030 Selection SHALL use pending as registered; lines captured in the current cycle are not eligible until the next cycle.
REQ-031 Latency: dec_valid at edge t gives pending at t+1 and evt_valid at t+2 when the FSM is idle.
REQ-032 A line re-arriving while its index is being offered is a new pending event, not a drop.
REQ-033 Outputs SHALL be registered, with no combinational path from dec_in or evt_ready to any output.

Reset
REQ-034 rst=1 SHALL force FSM=IDLE, evt_valid=0, evt_idx=0, pending=0, onehot_err=0, drop_cnt=0 and last_grant=N_LINES-1, so the first search starts at line 0.
REQ-035 Reset mid-OFFER SHALL discard the offered event and all pending events without a handshake.
REQ-036 dec_valid in the reset cycle SHALL be ignored.

Verification
REQ-037 Single event: dec_in=16'h0010 with dec_valid, evt_ready=1 -> evt_valid at t+2, evt_idx=4, one transfer, then IDLE, pending=0.
REQ-038 Round-robin wrap: capture 16'h8003 in one cycle, evt_ready=1 -> onehot_err=1, evt_idx sequence 0,1,15 on consecutive cycles; then capture 16'h0003 -> order 0,1.
REQ-039 Backpressure: offer idx 2 with evt_ready=0 for 5 cycles -> evt_idx=2 and evt_valid=1 stable throughout; accepted on the first cycle evt_ready=1.
REQ-040 Drop and saturation: hold line 5 pending (evt_ready=0, another line offered) and send 16'h0020 300 times -> drop_cnt=255, pending[5]=1.
REQ-041 Zero vector: dec_valid with dec_in=0 -> onehot_err=1, pending unchanged, evt_valid stays 0.
REQ-042 Reset mid-operation: rst during OFFER with 3 lines pending -> next cycle all outputs at reset values; first post-reset event 16'h0001 gives evt_idx=0.
